bus_terminator: RTL and testbench

BUS_TERMINATOR -- requirements
Module: bus_terminator

---
 rtl/bus_pkg.sv | 37 +++
 rtl/wait_counter.sv | 33 +++
 rtl/bus_terminator.sv | 167 ++++++++++++++++
 tb/tb_bus_terminator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared encodings for the bus terminator: decoded regions, FSM states and
// the CPU dynamic-size acknowledge codes.
package bus_pkg;

  typedef enum logic [1:0] {
    REGION_UNMAPPED = 2'b00,
    REGION_ROM      = 2'b01,
    REGION_RAM      = 2'b10,
    REGION_IO       = 2'b11
  } region_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_EXTERN = 3'd2,
    ST_ACK    = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  localparam logic [1:0] DSACK_BYTE = 2'b10;
  localparam logic [1:0] DSACK_WORD = 2'b01;
  localparam logic [1:0] DSACK_LONG = 2'b00;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  // Port width of each target as seen by the CPU: ROM 8-bit, RAM 32-bit, I/O 16-bit.
  function automatic logic [1:0] dsackForRegion(input region_e r);
    logic [1:0] code;
    case (r)
      REGION_ROM: code = DSACK_BYTE;
      REGION_RAM: code = DSACK_LONG;
      REGION_IO:  code = DSACK_WORD;
      default:    code = DSACK_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable 4-bit down-counter with a zero flag; times the memory wait states.
module wait_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] value_i,
  input  logic       enable_i,
  output logic       zero_o
);

  logic [3:0] count_q, count_d;

  // Load wins over decrement; the count rests at zero rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (enable_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/bus_terminator.sv
// CPU bus-cycle terminator: generates DSACK for ROM/RAM/I/O and optional bus error.
// Define BUS_TIMEOUT_EN to build the timeout counter and the ERROR/berr_n path.
module bus_terminator
  import bus_pkg::*;
#(
  parameter int ROM_WAIT       = 3,
  parameter int RAM_WAIT       = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_address_strobe,
  input  logic [1:0] region,
  input  logic       io_ack_n,
  output logic [1:0] dsack_n,
  output logic       berr_n,
  output logic       busy
);

  localparam logic [3:0] ROM_LOAD = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_LOAD = 4'(RAM_WAIT);

  state_e     state_q, state_d;
  region_e    regionLatch_q, regionLatch_d;
  logic [1:0] dsack_q, dsack_d;
  logic       strobe_q;
  logic       ioAck_q;
  logic       armed_q, armed_d;
  logic       startCycle;
  logic       timedOut;
  logic       waitLoad;
  logic [3:0] waitValue;
  logic       waitEnable;
  logic       waitZero;

  // A cycle may only begin once IDLE has been held for a clock with the strobe high.
  assign startCycle = (state_q == ST_IDLE) && !strobe_q && armed_q;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] timeout_q, timeout_d;
  logic       berr_q, berr_d;

  always_comb begin
    timeout_d = timeout_q;
    if (startCycle) begin
      timeout_d = 8'd0;
    end else if ((state_q == ST_WAIT) || (state_q == ST_EXTERN)) begin
      timeout_d = timeout_q + 8'd1;
    end
  end

  assign timedOut = (timeout_q == TIMEOUT_LAST);
  assign berr_d   = !((state_q == ST_ERROR) && (state_d == ST_ERROR));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_q <= 8'd0;
      berr_q    <= 1'b1;
    end else begin
      timeout_q <= timeout_d;
      berr_q    <= berr_d;
    end
  end

  assign berr_n = berr_q;
`else
  assign timedOut = 1'b0;
  assign berr_n   = 1'b1;
`endif

  wait_counter u_wait_counter (
    .clock    (clock),
    .reset    (reset),
    .load_i   (waitLoad),
    .value_i  (waitValue),
    .enable_i (waitEnable),
    .zero_o   (waitZero)
  );

  always_comb begin
    state_d       = state_q;
    regionLatch_d = regionLatch_q;
    waitLoad      = 1'b0;
    waitValue     = 4'd0;
    waitEnable    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (startCycle) begin
          regionLatch_d = region_e'(region);
          case (region_e'(region))
            REGION_ROM: begin
              waitLoad  = 1'b1;
              waitValue = ROM_LOAD;
              state_d   = ST_WAIT;
            end
            REGION_RAM: begin
              waitLoad  = 1'b1;
              waitValue = RAM_LOAD;
              state_d   = ST_WAIT;
            end
            default: state_d = ST_EXTERN;
          endcase
        end
      end
      ST_WAIT: begin
        if (strobe_q) begin
          state_d = ST_IDLE;
        end else if (waitZero) begin
          state_d = ST_ACK;
        end else if (timedOut) begin
          state_d = ST_ERROR;
        end else begin
          waitEnable = 1'b1;
        end
      end
      ST_EXTERN: begin
        // Unmapped cycles never acknowledge here; only a timeout or strobe release ends them.
        if (strobe_q) begin
          state_d = ST_IDLE;
        end else if (!ioAck_q && (regionLatch_q == REGION_IO)) begin
          state_d = ST_ACK;
        end else if (timedOut) begin
          state_d = ST_ERROR;
        end
      end
      ST_ACK, ST_ERROR: begin
        if (strobe_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // DSACK asserts one clock into ACK and drops on the same edge that returns to IDLE.
  always_comb begin
    armed_d = (state_d == ST_IDLE) && strobe_q;
    dsack_d = DSACK_NONE;
    if ((state_q == ST_ACK) && (state_d == ST_ACK)) begin
      dsack_d = dsackForRegion(regionLatch_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe_q      <= 1'b1;
      ioAck_q       <= 1'b1;
      armed_q       <= 1'b0;
      state_q       <= ST_IDLE;
      regionLatch_q <= REGION_UNMAPPED;
      dsack_q       <= DSACK_NONE;
    end else begin
      strobe_q      <= cpu_address_strobe;
      ioAck_q       <= io_ack_n;
      armed_q       <= armed_d;
      state_q       <= state_d;
      regionLatch_q <= regionLatch_d;
      dsack_q       <= dsack_d;
    end
  end

  assign dsack_n = dsack_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_terminator.sv
// Directed self-checking bench for bus_terminator (ROM_WAIT=3, RAM_WAIT=0, TIMEOUT_CYCLES=64).
module tb_bus_terminator;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_address_strobe;
  logic [1:0] region;
  logic       io_ack_n;
  logic [1:0] dsack_n;
  logic       berr_n;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  bus_terminator #(
    .ROM_WAIT       (3),
    .RAM_WAIT       (0),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .cpu_address_strobe (cpu_address_strobe),
    .region             (region),
    .io_ack_n           (io_ack_n),
    .dsack_n            (dsack_n),
    .berr_n             (berr_n),
    .busy               (busy)
  );

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_address_strobe = 1'b1;
    io_ack_n = 1'b1;
    region = 2'b00;
    tick(2);
    checks++;
    if (dsack_n !== 2'b11) begin errors++; $display("[TB] FAIL reset_dsack: got %b expected 11", dsack_n); end
    checks++;
    if (berr_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_berr: got %b expected 1", berr_n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    tick(1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_rom_cycle();
    logic [1:0] exp;
    region = 2'b01;
    cpu_address_strobe = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      tick(1);
      exp = (n == 7) ? 2'b10 : 2'b11;
      checks++;
      if (dsack_n !== exp) begin errors++; $display("[TB] FAIL rom_dsack_n%0d: got %b expected %b", n, dsack_n, exp); end
      if (n == 1) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rom_busy_n1: got %b expected 0", busy); end
      end
      if (n == 2) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rom_busy_n2: got %b expected 1", busy); end
      end
      if (n == 3) region = 2'b10;
    end
    tick(2);
    checks++;
    if (dsack_n !== 2'b10) begin errors++; $display("[TB] FAIL rom_hold: got %b expected 10", dsack_n); end
    cpu_address_strobe = 1'b1;
    region = 2'b00;
    tick(1);
    checks++;
    if (dsack_n !== 2'b10) begin errors++; $display("[TB] FAIL rom_release_r0: got %b expected 10", dsack_n); end
    tick(1);
    checks++;
    if (dsack_n !== 2'b11) begin errors++; $display("[TB] FAIL rom_release_r1: got %b expected 11", dsack_n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rom_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_ram_cycle();
    logic [1:0] exp;
    region = 2'b10;
    cpu_address_strobe = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick(1);
      exp = (n == 4) ? 2'b00 : 2'b11;
      checks++;
      if (dsack_n !== exp) begin errors++; $display("[TB] FAIL ram_dsack_n%0d: got %b expected %b", n, dsack_n, exp); end
    end
    tick(1);
    checks++;
    if (dsack_n !== 2'b00) begin errors++; $display("[TB] FAIL ram_hold: got %b expected 00", dsack_n); end
    cpu_address_strobe = 1'b1;
    tick(2);
    checks++;
    if (dsack_n !== 2'b11) begin errors++; $display("[TB] FAIL ram_release: got %b expected 11", dsack_n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ram_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_io_cycle();
    logic [1:0] exp;
    region = 2'b11;
    cpu_address_strobe = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick(1);
      checks++;
      if (dsack_n !== 2'b11) begin errors++; $display("[TB] FAIL io_wait_dsack_n%0d: got %b expected 11", n, dsack_n); end
    end
    io_ack_n = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      tick(1);
      exp = (n == 3) ? 2'b01 : 2'b11;
      checks++;
      if (dsack_n !== exp) begin errors++; $display("[TB] FAIL io_dsack_n%0d: got %b expected %b", n, dsack_n, exp); end
      checks++;
      if (berr_n !== 1'b1) begin errors++; $display("[TB] FAIL io_berr_n%0d: got %b expected 1", n, berr_n); end
    end
    cpu_address_strobe = 1'b1;
    io_ack_n = 1'b1;
    tick(2);
    checks++;
    if (dsack_n !== 2'b11) begin errors++; $display("[TB] FAIL io_release: got %b expected 11", dsack_n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL io_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    logic expBerr;
    region = 2'b00;
    cpu_address_strobe = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      tick(1);
      if (n == 20) io_ack_n = 1'b0;
      if (n == 25) io_ack_n = 1'b1;
`ifdef BUS_TIMEOUT_EN
      expBerr = (n >= 67) ? 1'b0 : 1'b1;
`else
      expBerr = 1'b1;
`endif
      checks++;
      if (berr_n !== expBerr) begin errors++; $display("[TB] FAIL timeout_berr_n%0d: got %b expected %b", n, berr_n, expBerr); end
      checks++;
      if (dsack_n !== 2'b11) begin errors++; $display("[TB] FAIL timeout_dsack_n%0d: got %b expected 11", n, dsack_n); end
      if (n >= 2) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_busy_n%0d: got %b expected 1", n, busy); end
      end
    end
    cpu_address_strobe = 1'b1;
    tick(2);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_release_busy: got %b expected 0", busy); end
    checks++;
    if (berr_n !== 1'b1) begin errors++; $display("[TB] FAIL timeout_release_berr: got %b expected 1", berr_n); end
  endtask

  task automatic test_abort();
    region = 2'b01;
    cpu_address_strobe = 1'b0;
    tick(3);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_wait: got %b expected 1", busy); end
    cpu_address_strobe = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick(1);
      checks++;
      if (dsack_n !== 2'b11) begin errors++; $display("[TB] FAIL abort_dsack_n%0d: got %b expected 11", n, dsack_n); end
      if (n == 2) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy_idle: got %b expected 0", busy); end
      end
    end
  endtask

  task automatic test_reset_in_ack();
    logic [1:0] exp;
    region = 2'b10;
    cpu_address_strobe = 1'b0;
    tick(4);
    checks++;
    if (dsack_n !== 2'b00) begin errors++; $display("[TB] FAIL rack_pre_dsack: got %b expected 00", dsack_n); end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (dsack_n !== 2'b11) begin errors++; $display("[TB] FAIL rack_async_dsack: got %b expected 11", dsack_n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rack_async_busy: got %b expected 0", busy); end
    cpu_address_strobe = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rack_release_busy: got %b expected 0", busy); end
    cpu_address_strobe = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick(1);
      exp = (n == 4) ? 2'b00 : 2'b11;
      checks++;
      if (dsack_n !== exp) begin errors++; $display("[TB] FAIL rack_recover_n%0d: got %b expected %b", n, dsack_n, exp); end
    end
    cpu_address_strobe = 1'b1;
    tick(2);
  endtask

  task automatic test_back_to_back();
    logic [1:0] expDsack [1:5];
    logic       expBusy  [1:5];
    expDsack = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b00};
    expBusy  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    region = 2'b10;
    cpu_address_strobe = 1'b0;
    tick(4);
    checks++;
    if (dsack_n !== 2'b00) begin errors++; $display("[TB] FAIL b2b_first_ack: got %b expected 00", dsack_n); end
    cpu_address_strobe = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick(1);
      if (n == 1) cpu_address_strobe = 1'b0;
      checks++;
      if (dsack_n !== expDsack[n]) begin errors++; $display("[TB] FAIL b2b_dsack_n%0d: got %b expected %b", n, dsack_n, expDsack[n]); end
      checks++;
      if (busy !== expBusy[n]) begin errors++; $display("[TB] FAIL b2b_busy_n%0d: got %b expected %b", n, busy, expBusy[n]); end
    end
    cpu_address_strobe = 1'b1;
    tick(2);
    checks++;
    if (dsack_n !== 2'b11) begin errors++; $display("[TB] FAIL b2b_release: got %b expected 11", dsack_n); end
  endtask

  initial begin
    test_reset();
    test_rom_cycle();
    test_ram_cycle();
    test_io_cycle();
    test_timeout();
    test_abort();
    test_reset_in_ack();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
